quick_mem_responder: RTL and testbench

Memory-side responder for the quick CPU's byte-wide memory bus. It holds a small flop-based byte memory, answers CPU read strobes with one-cycle-latency data, and accepts CPU writes. A byte-serial loader fills the memory before or between program runs. It sits outside the CPU core, either in the test harness or in a companion tile, and drives the CPU's data input from the CPU's address output.

---
 rtl/quick_mem_pkg.sv | 17 +
 rtl/quick_mem_loader.sv | 65 ++++++
 rtl/quick_mem_responder.sv | 112 +++++++++++
 tb/tb_quick_mem_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/quick_mem_pkg.sv
// Shared types and defaults for the quick CPU memory responder.
// Holds the SERVE/LOAD state encoding and the address range check.
package quick_mem_pkg;

    typedef enum logic {
        SERVE = 1'b0,
        LOAD  = 1'b1
    } state_t;

    localparam int         DEFAULT_DEPTH = 32;
    localparam logic [7:0] DEFAULT_FILL  = 8'h00;

    function automatic logic in_range(input logic [7:0] addr, input int depth);
        return int'(addr) < depth;
    endfunction

endpackage

// File: rtl/quick_mem_loader.sv
// Byte-serial loader FSM: fills the memory from address 0 upward and
// reports completion. Drives a write port toward the memory array.
module quick_mem_loader
    import quick_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          ld_done,
    output logic          busy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SERVE;
            ptr      <= '0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                SERVE: begin
                    if (ld_start) begin
                        state    <= LOAD;
                        ptr      <= '0;
                        ld_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    // A restart takes priority over a byte offered on the same edge.
                    if (ld_start) begin
                        ptr <= '0;
                    end else if (ld_valid) begin
                        ptr <= ptr + AW'(1);
                        if (ptr == LAST) begin
                            state    <= SERVE;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy    = (state == LOAD);
    assign wr_en   = busy & ld_valid & ~ld_start;
    assign wr_addr = ptr;
    assign wr_data = ld_data;

endmodule

// File: rtl/quick_mem_responder.sv
// Memory-side responder for the quick CPU byte bus: flop-based byte memory
// with one-cycle read latency, CPU writes, and a byte-serial loader.
module quick_mem_responder
    import quick_mem_pkg::*;
#(
    parameter int         DEPTH = DEFAULT_DEPTH,
    parameter logic [7:0] FILL  = DEFAULT_FILL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] mem_addr,
    input  logic       mem_rd,
    input  logic       mem_wr,
    input  logic [7:0] mem_wdata,
    output logic [7:0] mem_rdata,
    output logic       mem_rvalid,
    input  logic       ld_start,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    output logic       ld_ready,
    output logic       ld_done,
    output logic       oob_err
);

    localparam int AW = $clog2(DEPTH);

    logic          busy;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_wdata;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] idx;
    logic          addr_ok;
    logic          cpu_we;
    logic          mem_we;
    logic [AW-1:0] we_addr;
    logic [7:0]    we_data;

    quick_mem_loader #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_loader (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .busy     (busy),
        .wr_en    (ld_we),
        .wr_addr  (ld_addr),
        .wr_data  (ld_wdata)
    );

    assign idx     = mem_addr[AW-1:0];
    assign addr_ok = in_range(mem_addr, DEPTH);
    assign cpu_we  = mem_wr & ~busy & addr_ok;

    always_comb begin
        mem_we  = 1'b0;
        we_addr = idx;
        we_data = mem_wdata;
        if (ld_we) begin
            mem_we  = 1'b1;
            we_addr = ld_addr;
            we_data = ld_wdata;
        end else if (cpu_we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem[we_addr] <= we_data;
        end
    end

    // Read path samples the pre-write array, so a same-edge rd+wr returns the old byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata  <= 8'h00;
            mem_rvalid <= 1'b0;
        end else begin
            mem_rvalid <= 1'b0;
            if (mem_rd) begin
                if (busy) begin
                    mem_rdata <= FILL;
                end else begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= addr_ok ? mem[idx] : FILL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_err <= 1'b0;
        end else if (ld_start) begin
            oob_err <= 1'b0;
        end else if (~busy & (mem_rd | mem_wr) & ~addr_ok) begin
            oob_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_quick_mem_responder.sv
// Directed self-checking bench for quick_mem_responder (DEPTH 32, FILL 00).
module tb_quick_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mem_addr = 8'h00;
    logic       mem_rd = 1'b0;
    logic       mem_wr = 1'b0;
    logic [7:0] mem_wdata = 8'h00;
    logic [7:0] mem_rdata;
    logic       mem_rvalid;
    logic       ld_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = 8'h00;
    logic       ld_ready;
    logic       ld_done;
    logic       oob_err;

    int errors = 0;
    int checks = 0;

    quick_mem_responder #(
        .DEPTH (32),
        .FILL  (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .oob_err    (oob_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [7:0] a);
        mem_addr = a;
        mem_rd   = 1'b1;
        step();
        mem_rd   = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_wr    = 1'b1;
        step();
        mem_wr    = 1'b0;
    endtask

    task automatic load_bytes(input int first, input int count, input logic [7:0] base,
                              output int done_seen);
        done_seen = 0;
        for (int i = 0; i < count; i++) begin
            ld_valid = 1'b1;
            ld_data  = base + 8'(first + i);
            step();
            if (ld_done) done_seen++;
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", mem_rdata); end
        checks++; if (mem_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", mem_rvalid); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b expected 0", ld_ready); end
        checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL reset_oob: got %b expected 0", oob_err); end
        cpu_read(8'd7);
        checks++; if (mem_rdata !== 8'h00 || mem_rvalid !== 1'b1) begin errors++; $display("FAIL reset_read7: got %h/%b expected 00/1", mem_rdata, mem_rvalid); end
        $display("test_reset: done, errors so far %0d", errors);
    endtask

    task automatic test_load();
        int n = 0;
        int done_cnt = 0;
        int done_at = -1;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready_rise: got %b expected 1", ld_ready); end
        for (int c = 0; c < 100 && n < 32; c++) begin
            ld_valid = ((c % 3) != 2);
            ld_data  = 8'h10 + 8'(n);
            step();
            if (ld_valid) n++;
            if (ld_done) begin done_cnt++; done_at = n; end
        end
        ld_valid = 1'b0;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL load_ready_fall: got %b expected 0", ld_ready); end
        repeat (3) begin
            step();
            if (ld_done) done_cnt++;
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL load_count: got %0d expected 32", n); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL load_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (done_at !== 32) begin errors++; $display("FAIL load_done_timing: got %0d expected 32", done_at); end
        cpu_read(8'd5);
        checks++; if (mem_rdata !== 8'h15 || mem_rvalid !== 1'b1) begin errors++; $display("FAIL load_read5: got %h/%b expected 15/1", mem_rdata, mem_rvalid); end
        step();
        checks++; if (mem_rvalid !== 1'b0 || mem_rdata !== 8'h15) begin errors++; $display("FAIL load_hold: got %h/%b expected 15/0", mem_rdata, mem_rvalid); end
        cpu_read(8'd31);
        checks++; if (mem_rdata !== 8'h2F) begin errors++; $display("FAIL load_read31: got %h expected 2F", mem_rdata); end
        $display("test_load: %0d bytes, %0d done pulses, errors so far %0d", n, done_cnt, errors);
    endtask

    task automatic test_write();
        cpu_write(8'd3, 8'hAB);
        cpu_read(8'd3);
        checks++; if (mem_rdata !== 8'hAB) begin errors++; $display("FAIL write_read3: got %h expected AB", mem_rdata); end
        mem_addr  = 8'd3;
        mem_wdata = 8'hCD;
        mem_rd    = 1'b1;
        mem_wr    = 1'b1;
        step();
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        checks++; if (mem_rdata !== 8'hAB || mem_rvalid !== 1'b1) begin errors++; $display("FAIL rdwr_old: got %h/%b expected AB/1", mem_rdata, mem_rvalid); end
        cpu_read(8'd3);
        checks++; if (mem_rdata !== 8'hCD) begin errors++; $display("FAIL rdwr_new: got %h expected CD", mem_rdata); end
        $display("test_write: errors so far %0d", errors);
    endtask

    task automatic test_oob();
        cpu_read(8'h40);
        checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL oob_rdata: got %h expected 00", mem_rdata); end
        checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_set: got %b expected 1", oob_err); end
        repeat (3) step();
        checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b expected 1", oob_err); end
        cpu_write(8'h40, 8'h99);
        cpu_read(8'd0);
        checks++; if (mem_rdata !== 8'h10) begin errors++; $display("FAIL oob_write_dropped: got %h expected 10", mem_rdata); end
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL oob_clear: got %b expected 0", oob_err); end
        $display("test_oob: errors so far %0d", errors);
    endtask

    // Entered with a load already started by test_oob.
    task automatic test_load_access();
        int d1, d2;
        load_bytes(0, 5, 8'h80, d1);
        cpu_read(8'd2);
        checks++; if (mem_rvalid !== 1'b0 || mem_rdata !== 8'h00) begin errors++; $display("FAIL load_cpu_read: got %h/%b expected 00/0", mem_rdata, mem_rvalid); end
        cpu_read(8'h40);
        checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL load_oob: got %b expected 0", oob_err); end
        cpu_write(8'd2, 8'h55);
        load_bytes(5, 27, 8'h80, d2);
        checks++; if (d1 + d2 !== 1 || ld_done !== 1'b1) begin errors++; $display("FAIL load2_done: got %0d pulses, done=%b expected 1/1", d1 + d2, ld_done); end
        cpu_read(8'd2);
        checks++; if (mem_rdata !== 8'h82) begin errors++; $display("FAIL load_write_lost: got %h expected 82", mem_rdata); end
        $display("test_load_access: errors so far %0d", errors);
    endtask

    task automatic test_back_to_back();
        mem_rd   = 1'b1;
        mem_addr = 8'd1;
        step();
        checks++; if (mem_rdata !== 8'h81 || mem_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%b expected 81/1", mem_rdata, mem_rvalid); end
        mem_addr = 8'd2;
        step();
        checks++; if (mem_rdata !== 8'h82 || mem_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b expected 82/1", mem_rdata, mem_rvalid); end
        mem_rd = 1'b0;
        step();
        checks++; if (mem_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", mem_rvalid); end
        $display("test_back_to_back: errors so far %0d", errors);
    endtask

    task automatic test_reset_midload();
        int d;
        int bad = 0;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        load_bytes(0, 10, 8'h60, d);
        rst_n = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ld_ready); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (ld_done !== 1'b0 || d !== 0) begin errors++; $display("FAIL rst_no_done: got %b/%0d expected 0/0", ld_done, d); end
        for (int a = 0; a < 10; a++) begin
            cpu_read(8'(a));
            if (mem_rdata !== 8'h00 || mem_rvalid !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rst_cleared: got %0d bad reads expected 0", bad); end
        cpu_read(8'd20);
        checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL rst_cleared20: got %h expected 00", mem_rdata); end
        $display("test_reset_midload: errors so far %0d", errors);
    endtask

    initial begin
        test_reset();
        test_load();
        test_write();
        test_oob();
        test_load_access();
        test_back_to_back();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
